// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one sram controller between N_PORTS requesters.
// Tags each issued read so returned words are steered back to the issuing port.
module sram_arbiter #(
    parameter int unsigned N_PORTS      = 2,
    parameter int unsigned ADDR_W       = 18,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned READ_LATENCY = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic [N_PORTS-1:0]         i_req,
    input  logic [N_PORTS-1:0]         i_rnw,
    input  logic [N_PORTS*ADDR_W-1:0]  i_addr,
    input  logic [N_PORTS*DATA_W-1:0]  i_wdata,
    output logic [N_PORTS-1:0]         o_ack,
    output logic [DATA_W-1:0]          o_rdata,
    output logic [N_PORTS-1:0]         o_rvalid,
    output logic                       o_error,
    output logic                       o_mem_start,
    output logic                       o_mem_rnw,
    output logic [ADDR_W-1:0]          o_mem_addr,
    output logic [DATA_W-1:0]          o_mem_wdata,
    input  logic                       i_mem_busy,
    input  logic                       i_mem_rdata_valid,
    input  logic [DATA_W-1:0]          i_mem_rdata
);

    localparam int unsigned PtrW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [PtrW-1:0]                      r_last;
    logic [READ_LATENCY-1:0]              r_tag_vld;
    logic [READ_LATENCY-1:0][PtrW-1:0]    r_tag_port;
    logic [DATA_W-1:0]                    r_rdata;
    logic [N_PORTS-1:0]                   r_rvalid;
    logic                                 r_error;

    logic [N_PORTS-1:0]                   w_mask;
    logic [N_PORTS-1:0]                   w_req_hi;
    logic [PtrW-1:0]                      w_gnt_idx;
    logic                                 w_grant;
    logic                                 w_tail_vld;
    logic                                 w_ret;

    // Ports above last take priority; lowest such requester wins, else lowest overall.
    always_comb begin
        w_mask = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (p > int'(r_last)) begin
                w_mask[p] = 1'b1;
            end
        end
        w_req_hi  = i_req & w_mask;
        w_gnt_idx = '0;
        for (int p = N_PORTS - 1; p >= 0; p--) begin
            if (i_req[p]) begin
                w_gnt_idx = PtrW'(p);
            end
        end
        for (int p = N_PORTS - 1; p >= 0; p--) begin
            if (w_req_hi[p]) begin
                w_gnt_idx = PtrW'(p);
            end
        end
    end

    assign w_grant = !i_mem_busy && (|i_req);

    always_comb begin
        o_ack       = '0;
        o_mem_start = 1'b0;
        o_mem_rnw   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_grant) begin
            o_ack       = N_PORTS'(1) << w_gnt_idx;
            o_mem_start = 1'b1;
            o_mem_rnw   = i_rnw[w_gnt_idx];
            o_mem_addr  = i_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
            o_mem_wdata = i_wdata[int'(w_gnt_idx)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_last <= PtrW'(N_PORTS - 1);
        end else if (w_grant) begin
            r_last <= w_gnt_idx;
        end
    end

    // Tag pipeline: tail stage lines up with the controller's read data.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tag_vld  <= '0;
            r_tag_port <= '0;
        end else begin
            r_tag_vld[0]  <= o_mem_start & o_mem_rnw;
            r_tag_port[0] <= w_gnt_idx;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_tag_vld[k]  <= r_tag_vld[k-1];
                r_tag_port[k] <= r_tag_port[k-1];
            end
        end
    end

    assign w_tail_vld = r_tag_vld[READ_LATENCY-1];
    assign w_ret      = i_mem_rdata_valid && w_tail_vld;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rdata  <= '0;
            r_rvalid <= '0;
            r_error  <= 1'b0;
        end else begin
            r_rvalid <= w_ret ? (N_PORTS'(1) << r_tag_port[READ_LATENCY-1]) : '0;
            if (w_ret) begin
                r_rdata <= i_mem_rdata;
            end
            // Data without a tag, or a tag without data, is unrecoverable.
            if (i_mem_rdata_valid != w_tail_vld) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;
    assign o_error  = r_error;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter (3 ports): bench-side sram stand-in plus
// a transaction-level model of grants, read returns and the sticky error.
module tb_sram_arbiter;

    localparam int N  = 3;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int RL = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, rnw;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    ack, rvalid;
    logic [DW-1:0]   rdata;
    logic            err;
    logic            mstart, mrnw;
    logic [AW-1:0]   maddr;
    logic [DW-1:0]   mwdata;
    logic            mbusy, mrv;
    logic [DW-1:0]   mrdata;

    always #5 clk = ~clk;

    sram_arbiter #(
        .N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_rnw(rnw), .i_addr(addr),
        .i_wdata(wdata), .o_ack(ack), .o_rdata(rdata), .o_rvalid(rvalid), .o_error(err),
        .o_mem_start(mstart), .o_mem_rnw(mrnw), .o_mem_addr(maddr), .o_mem_wdata(mwdata),
        .i_mem_busy(mbusy), .i_mem_rdata_valid(mrv), .i_mem_rdata(mrdata)
    );

    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           pend[$];
    int            cyc;
    int            m_last;
    int            m_rv_port;
    logic [DW-1:0] m_rdata;
    logic          m_err;
    int            busy_cyc;
    logic [DW-1:0] rd_word;
    int            grant_seen;
    int            checks;
    int            failures;

    // One clock cycle: entered and left at posedge+1.
    task automatic cycle(input logic [N-1:0] r_in, input logic [N-1:0] rnw_in,
                         input bit inject, input bit drop);
        bit            due, drive;
        int            g;
        logic [N-1:0]  exp_ack, exp_rv;
        logic [AW+DW+1:0] exp_cmd;
        req   = r_in;
        rnw   = rnw_in;
        due   = (pend.size() > 0) && (pend[0].due == cyc);
        drive = (due && !drop) || inject;
        mbusy = (busy_cyc == cyc);
        mrv   = drive;
        mrdata = due ? pend[0].data : DW'($urandom);
        #3;
        g = -1;
        if (!mbusy) begin
            for (int k = 1; k <= N; k++) begin
                int p;
                p = (m_last + k) % N;
                if (g < 0 && r_in[p]) g = p;
            end
        end
        exp_ack = '0;
        exp_cmd = '0;
        if (g >= 0) begin
            exp_ack[g] = 1'b1;
            exp_cmd = {1'b1, rnw_in[g], addr[g*AW +: AW], wdata[g*DW +: DW]};
        end
        checks++;
        if (ack !== exp_ack) begin
            failures++;
            $display("FAIL ack cyc=%0d got=%b exp=%b", cyc, ack, exp_ack);
        end
        checks++;
        if ({mstart, mrnw, maddr, mwdata} !== exp_cmd) begin
            failures++;
            $display("FAIL mem_cmd cyc=%0d got=%h exp=%h", cyc,
                     {mstart, mrnw, maddr, mwdata}, exp_cmd);
        end
        exp_rv = '0;
        if (m_rv_port >= 0) exp_rv[m_rv_port] = 1'b1;
        checks++;
        if (rvalid !== exp_rv || rdata !== m_rdata) begin
            failures++;
            $display("FAIL rvalid/rdata cyc=%0d got=%b/%h exp=%b/%h", cyc, rvalid, rdata,
                     exp_rv, m_rdata);
        end
        checks++;
        if (err !== m_err) begin
            failures++;
            $display("FAIL error cyc=%0d got=%b exp=%b", cyc, err, m_err);
        end
        m_rv_port = -1;
        if (due && drive) begin
            m_rv_port = pend[0].port;
            m_rdata   = pend[0].data;
        end
        if (drive != due) m_err = 1'b1;
        if (due) void'(pend.pop_front());
        if (g >= 0) begin
            m_last = g;
            if (rnw_in[g]) begin
                rd_t t;
                t.due  = cyc + RL;
                t.port = g;
                t.data = rd_word;
                pend.push_back(t);
                rd_word = rd_word + 1'b1;
            end else begin
                busy_cyc = cyc + 1;
            end
        end
        grant_seen = g;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        mbusy = 1'b0;
        mrv   = 1'b0;
        #3;
        checks++;
        if (rvalid !== '0 || rdata !== '0 || err !== 1'b0 || ack !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rv=%b rd=%h err=%b ack=%b exp 0", rvalid, rdata,
                     err, ack);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pend.delete();
        m_last    = N - 1;
        m_rv_port = -1;
        m_rdata   = '0;
        m_err     = 1'b0;
        busy_cyc  = -10;
        cyc++;
    endtask

    task automatic test_reset();
        do_reset();
        idle(2);
    endtask

    task automatic test_single_read();
        do_reset();
        addr[0 +: AW] = 18'h00010;
        rd_word = 16'hDEAD;
        cycle(3'b001, 3'b001, 1'b0, 1'b0);
        checks++;
        if (grant_seen != 0) begin
            failures++;
            $display("FAIL single_read_grant got=%0d exp=0", grant_seen);
        end
        idle(4);
        checks++;
        if (rvalid !== 3'b001 || rdata !== 16'hDEAD || err !== 1'b0) begin
            failures++;
            $display("FAIL single_read_return got=%b/%h/%b exp=001/dead/0", rvalid, rdata, err);
        end
        idle(3);
    endtask

    task automatic test_alternating();
        do_reset();
        rd_word = 16'h1000;
        for (int i = 0; i < 6; i++) begin
            cycle(3'b011, 3'b011, 1'b0, 1'b0);
            checks++;
            if (grant_seen != i % 2) begin
                failures++;
                $display("FAIL alternating_grant i=%0d got=%0d exp=%0d", i, grant_seen, i % 2);
            end
        end
        idle(RL + 3);
    endtask

    task automatic test_write_stall();
        do_reset();
        cycle(3'b001, 3'b001, 1'b0, 1'b0);
        addr[AW +: AW]  = 18'h2;
        wdata[DW +: DW] = 16'h1234;
        cycle(3'b011, 3'b001, 1'b0, 1'b0);
        checks++;
        if (grant_seen != 1) begin
            failures++;
            $display("FAIL write_wins got=%0d exp=1", grant_seen);
        end
        cycle(3'b001, 3'b001, 1'b0, 1'b0);
        checks++;
        if (grant_seen != -1) begin
            failures++;
            $display("FAIL busy_stall got=%0d exp=-1", grant_seen);
        end
        cycle(3'b001, 3'b001, 1'b0, 1'b0);
        checks++;
        if (grant_seen != 0) begin
            failures++;
            $display("FAIL after_write got=%0d exp=0", grant_seen);
        end
        idle(RL + 3);
    endtask

    task automatic test_three_port();
        int exp_order[6] = '{0, 1, 2, 0, 2, 0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle((i < 2) ? 3'b111 : 3'b101, 3'b111, 1'b0, 1'b0);
            checks++;
            if (grant_seen != exp_order[i]) begin
                failures++;
                $display("FAIL three_port_order i=%0d got=%0d exp=%0d", i, grant_seen,
                         exp_order[i]);
            end
        end
        idle(RL + 3);
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(3'b001, 3'b001, 1'b0, 1'b0);
        cycle(3'b010, 3'b010, 1'b0, 1'b0);
        idle(2);
        do_reset();
        idle(RL + 3);
        cycle(3'b111, 3'b111, 1'b0, 1'b0);
        checks++;
        if (grant_seen != 0) begin
            failures++;
            $display("FAIL post_reset_grant got=%0d exp=0", grant_seen);
        end
        idle(RL + 3);
    endtask

    task automatic test_error();
        do_reset();
        cycle('0, '0, 1'b1, 1'b0);
        idle(3);
        checks++;
        if (err !== 1'b1 || rvalid !== '0) begin
            failures++;
            $display("FAIL error_sticky got=%b/%b exp=1/000", err, rvalid);
        end
        do_reset();
        cycle(3'b100, 3'b100, 1'b0, 1'b0);
        for (int i = 0; i < RL + 2; i++) cycle('0, '0, 1'b0, 1'b1);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL lost_read_error got=%b exp=1", err);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] busy_cmd;
        logic [N-1:0] cmd_rnw;
        do_reset();
        busy_cmd = '0;
        cmd_rnw  = '0;
        rd_word  = DW'($urandom);
        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p < N; p++) begin
                if (!busy_cmd[p] && ($urandom_range(1, 0) == 1)) begin
                    busy_cmd[p] = 1'b1;
                    cmd_rnw[p]  = ($urandom_range(3, 0) != 0);
                    addr[p*AW +: AW]  = AW'($urandom);
                    wdata[p*DW +: DW] = DW'($urandom);
                end
            end
            cycle(busy_cmd, cmd_rnw, 1'b0, 1'b0);
            if (grant_seen >= 0) busy_cmd[grant_seen] = 1'b0;
        end
        idle(RL + 3);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        req       = '0;
        rnw       = '0;
        addr      = '0;
        wdata     = '0;
        mbusy     = 1'b0;
        mrv       = 1'b0;
        mrdata    = '0;
        rd_word   = '0;
        busy_cyc  = -10;
        m_rv_port = -1;
        #1;
        test_reset();
        test_single_read();
        test_alternating();
        test_write_stall();
        test_three_port();
        test_reset_mid();
        test_error();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Round-robin arbiter that shares the single `sram` controller between `N_PORTS` requesters, e.g. a pixel writer and a display reader. It owns the controller's command interface and sequences one command at a time while honouring the controller's `busy`. It tracks every outstanding read through a tag pipeline matched to the controller's fixed read latency, so each returned word is steered to the port that issued it. It sits between the requester blocks and `sram`, which keeps the external bus pins.

## Interface
- `N_PORTS`, default 2: number of requesters (2..8).
- `ADDR_W`, default 18: word address width.
- `DATA_W`, default 16: data width.
- `READ_LATENCY`, default 4: cycles from the `o_mem_start` cycle (read) to `i_mem_rdata_valid`.

Ports:
- `i_clk`  in  1  clock.
- `i_reset_n`  in  1  reset, asynchronous assert, active low. One clock; reset is asynchronous and active-low.
- `i_req`  in  N_PORTS  per-port command request.
- `i_rnw`  in  N_PORTS  per-port: 1 = read, 0 = write.
- `i_addr`  in  N_PORTS*ADDR_W  per-port address, port p at bits [p*ADDR_W +: ADDR_W].
- `i_wdata`  in  N_PORTS*DATA_W  per-port write data.
- `o_ack`  out  N_PORTS  one-hot, combinational: command from that port accepted this cycle.
- `o_rdata`  out  DATA_W  registered read data, shared by all ports.
- `o_rvalid`  out  N_PORTS  registered one-hot: `o_rdata` belongs to that port.
- `o_error`  out  1  sticky: read data arrived with no matching tag.
- `o_mem_start`, `o_mem_rnw`, `o_mem_addr`, `o_mem_wdata`  out  1/1/ADDR_W/DATA_W  to `sram` `i_start`/`i_rnw`/`i_addr`/`i_wdata`.
- `i_mem_busy`, `i_mem_rdata_valid`, `i_mem_rdata`  in  1/1/DATA_W  from `sram`.

## Operation
- Grant, all combinational:
  - If `i_mem_busy`=0 and any `i_req` is high, the arbiter picks port g.
  - g is the first requesting port searching cyclically from `last+1`.
  - For port g: `o_ack[g]`=1, `o_mem_start`=1, and `o_mem_rnw`/`o_mem_addr`/`o_mem_wdata` come from port g.
  - Otherwise `o_mem_start`=0, all `o_ack`=0, and the mem command outputs are 0.
- Round-robin pointer `last`, clog2(N_PORTS) bits:
  - Loads g on every grant.
  - Resets to N_PORTS-1, so port 0 wins first.
- Requester rule:
  - Hold `i_req`, `i_rnw`, `i_addr`, `i_wdata` stable until `o_ack`.
  - The command is consumed in the ack cycle.
  - Keeping `i_req` high after ack presents the next command.
- Writes: the controller raises `i_mem_busy` for one cycle after the write start, so no grant is issued in that cycle. This is the only stall source.
- Reads may issue every cycle (pipelined).
- Tag pipeline, `READ_LATENCY` stages of {valid, port}:
  - stage[0] ← {o_mem_start & o_mem_rnw, g}.
  - stage[k] ← stage[k-1].
  - Shifts every cycle.
- Return path:
  - When `i_mem_rdata_valid`=1 and stage[READ_LATENCY-1].valid=1: next cycle `o_rdata` ← `i_mem_rdata` and `o_rvalid` ← onehot(stage port).
  - Otherwise `o_rvalid` ← 0 and `o_rdata` holds.
  - If `i_mem_rdata_valid`=1 and the tail tag is invalid, set `o_error`.
  - If the tail tag is valid and `i_mem_rdata_valid`=0, set `o_error`; the read is lost.
  - `o_error` clears only on reset.
- Reset mid-operation: tags, `last`, and outputs clear immediately. Outstanding reads are dropped with no `o_rvalid`. The controller is reset by the same signal.

## Timing
- Reset values: `o_rdata`=0, `o_rvalid`=0, `o_error`=0, `last`=N_PORTS-1, all tags invalid.
- `o_ack`/`o_mem_*` are combinational from `i_req`, `i_mem_busy` and `last`; zero-cycle grant.
- Read: ack in cycle t; `i_mem_rdata_valid` at t+READ_LATENCY; `o_rvalid` at t+READ_LATENCY+1 (5 by default).
- Write: ack in cycle t; bus write in t+1 (busy=1); next grant is possible at t+2.
- Throughput: 1 read/cycle; 1 write per 2 cycles.
- Simultaneous requests: exactly one ack per cycle. With all ports requesting continuously, each port is granted once every N_PORTS grants.
- Single requester: it is granted every non-busy cycle regardless of `last`.

## Test plan
- Reset, then port 0 reads 0x00010 once; bench returns 0xDEAD at the 4th cycle → `o_ack`=01 in t, `o_rvalid`=01 with `o_rdata`=0xDEAD at t+5, `o_error`=0.
- Ports 0 and 1 hold reads continuously for 6 cycles → acks alternate 01,10,01,…, starting with port 0. The returned words 0x1000+n are delivered on `o_rvalid` alternating 01,10 with matching data, 5 cycles after each ack.
- Port 1 writes 0x1234 to addr 0x2 while port 0 requests a read → port 1 wins if `last`=0. `i_mem_busy` next cycle gives no ack. Port 0 is acked 2 cycles after the write ack.
- Three ports (N_PORTS=3) all requesting with port 1 released after its first ack → grant order 0,1,2,0,2,0.
- Reads issued in 2 consecutive cycles, `i_reset_n` pulsed low 2 cycles later → no `o_rvalid` afterwards, `o_error`=0, and the first post-reset grant goes to port 0.
- Inject `i_mem_rdata_valid`=1 with no outstanding read → `o_error`=1 next cycle and stays high until reset; `o_rvalid` stays 0.
